// File: rtl/rr_output_arbiter.sv
// Round-robin / fixed-priority arbiter for a single NOC router output port.
// The grant is locked for a whole packet and is released by the tail flit.
module rr_output_arbiter #(
  parameter int                NUM_REQ = 4,
  parameter int                ADDR_W  = 3,
  parameter logic [ADDR_W-1:0] PORT_ID = 3'd3,
  parameter int                MODE    = 0,
  localparam int               IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ*ADDR_W-1:0]   nexthop_addr_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic                        out_ready_i,
  input  logic                        release_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [IDX_W-1:0]            grant_idx_o,
  output logic                        grant_valid_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   grant_d;
  logic [IDX_W-1:0]     idx_d;
  logic                 valid_d;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req[k] = req_valid_i[k] && (nexthop_addr_i[k*ADDR_W +: ADDR_W] == PORT_ID);
    end
  end

  // Circular scan starting at the pointer; the wrap is an explicit subtract so
  // non-power-of-two requester counts rotate correctly.
  always_comb begin
    int start;
    int cand;
    win_idx   = '0;
    win_found = 1'b0;
    start     = (MODE == 1) ? 0 : int'(ptr_q);
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = start + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_o;
    idx_d   = grant_idx_o;
    valid_d = grant_valid_o;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (win_found && out_ready_i) begin
          grant_d = ONE_HOT0 << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Packet lock: nothing but the tail flit can change the grant.
        if (release_i) begin
          if (MODE == 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = (grant_idx_o == LAST_IDX) ? '0 : grant_idx_o + IDX_W'(1);
          end
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_o       <= '0;
      grant_idx_o   <= '0;
      grant_valid_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_o       <= grant_d;
      grant_idx_o   <= idx_d;
      grant_valid_o <= valid_d;
    end
  end

  a_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant_o));
  a_valid : assert property (@(posedge clk) disable iff (!reset)
    grant_valid_o == (|grant_o));
  a_index : assert property (@(posedge clk) disable iff (!reset)
    grant_o == (grant_valid_o ? (ONE_HOT0 << grant_idx_o) : '0));

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Self-checking bench: three arbiter flavours (4 req RR, 5 req RR, 4 req fixed)
// driven together and compared every cycle against a queue-based reference.
module tb_rr_output_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  vld;
  logic [14:0] addr;
  logic        rdy;
  logic        rel;

  logic [3:0] gnt_a;
  logic [1:0] idx_a;
  logic       gv_a;
  logic [4:0] gnt_b;
  logic [2:0] idx_b;
  logic       gv_b;
  logic [3:0] gnt_c;
  logic [1:0] idx_c;
  logic       gv_c;

  int n_compared   = 0;
  int n_mismatched = 0;

  int m_busy[3];
  int m_g[3];
  int m_ptr[3];

  localparam logic [14:0] ALL3 = 15'b011_011_011_011_011;
  localparam logic [14:0] FILT = 15'b000_011_001_011_010;

  always #5 clk = ~clk;

  rr_output_arbiter #(.NUM_REQ(4), .ADDR_W(3), .PORT_ID(3'd3), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .nexthop_addr_i(addr[11:0]), .req_valid_i(vld[3:0]),
    .out_ready_i(rdy), .release_i(rel), .grant_o(gnt_a), .grant_idx_o(idx_a),
    .grant_valid_o(gv_a));

  rr_output_arbiter #(.NUM_REQ(5), .ADDR_W(3), .PORT_ID(3'd3), .MODE(0)) dut_b (
    .clk(clk), .reset(reset), .nexthop_addr_i(addr), .req_valid_i(vld),
    .out_ready_i(rdy), .release_i(rel), .grant_o(gnt_b), .grant_idx_o(idx_b),
    .grant_valid_o(gv_b));

  rr_output_arbiter #(.NUM_REQ(4), .ADDR_W(3), .PORT_ID(3'd3), .MODE(1)) dut_c (
    .clk(clk), .reset(reset), .nexthop_addr_i(addr[11:0]), .req_valid_i(vld[3:0]),
    .out_ready_i(rdy), .release_i(rel), .grant_o(gnt_c), .grant_idx_o(idx_c),
    .grant_valid_o(gv_c));

  function automatic int numOf(int m);
    return (m == 1) ? 5 : 4;
  endfunction

  function automatic logic [31:0] expGrant(int m);
    return (m_busy[m] != 0) ? (32'd1 << m_g[m]) : 32'd0;
  endfunction

  function automatic logic [31:0] expIdx(int m);
    return (m_busy[m] != 0) ? 32'(m_g[m]) : 32'd0;
  endfunction

  // Reference: list the eligible requesters in priority order and take the head.
  task automatic modelStep();
    for (int m = 0; m < 3; m++) begin
      int n;
      int base;
      int order[$];
      n = numOf(m);
      if (!reset) begin
        m_busy[m] = 0;
        m_g[m]    = 0;
        m_ptr[m]  = 0;
      end else if (m_busy[m] != 0) begin
        if (rel) begin
          m_ptr[m]  = (m == 2) ? 0 : (m_g[m] + 1) % n;
          m_busy[m] = 0;
        end
      end else if (rdy) begin
        base = (m == 2) ? 0 : m_ptr[m];
        for (int i = 0; i < n; i++) begin
          int k;
          k = (base + i) % n;
          if (vld[k] && addr[k*3 +: 3] == 3'd3) order.push_back(k);
        end
        if (order.size() > 0) begin
          m_busy[m] = 1;
          m_g[m]    = order[0];
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("a_grant", 32'(gnt_a), expGrant(0));
    checkOutput("a_idx",   32'(idx_a), expIdx(0));
    checkOutput("a_valid", 32'(gv_a),  32'(m_busy[0] != 0));
    checkOutput("b_grant", 32'(gnt_b), expGrant(1));
    checkOutput("b_idx",   32'(idx_b), expIdx(1));
    checkOutput("b_valid", 32'(gv_b),  32'(m_busy[1] != 0));
    checkOutput("c_grant", 32'(gnt_c), expGrant(2));
    checkOutput("c_idx",   32'(idx_c), expIdx(2));
    checkOutput("c_valid", 32'(gv_c),  32'(m_busy[2] != 0));
  endtask

  // Inputs change on the falling edge, outputs are checked on the next one.
  task automatic applyStimulus(input logic r, input logic [4:0] v, input logic [14:0] a,
                               input logic rd, input logic rl);
    reset = r;
    vld   = v;
    addr  = a;
    rdy   = rd;
    rel   = rl;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    logic [14:0] ra;
    for (int m = 0; m < 3; m++) begin
      m_busy[m] = 0;
      m_g[m]    = 0;
      m_ptr[m]  = 0;
    end
    reset = 1'b0;
    vld   = '0;
    addr  = '0;
    rdy   = 1'b0;
    rel   = 1'b0;
    @(negedge clk);

    $display("[TB] reset with all requesters active");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'h1f, ALL3, 1'b1, 1'b0);
      checkOutput("rst_valid", 32'(gv_a), 32'd0);
    end
    applyStimulus(1'b1, 5'h1f, ALL3, 1'b1, 1'b0);
    checkOutput("rst_first_grant", 32'(gnt_a), 32'd1);

    $display("[TB] rotation");
    for (int i = 0; i < 5; i++) begin
      checkOutput("rot_idx", 32'(idx_a), 32'(i % 4));
      checkOutput("rot_valid", 32'(gv_a), 32'd1);
      applyStimulus(1'b1, 5'h1f, ALL3, 1'b1, 1'b1);
      checkOutput("rot_gap", 32'(gv_a), 32'd0);
      if (i < 4) applyStimulus(1'b1, 5'h1f, ALL3, 1'b1, 1'b0);
    end

    $display("[TB] address filter and fixed priority");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'h1f, FILT, 1'b1, 1'b0);
      checkOutput("filt_idx", 32'(idx_a), (i % 2 == 0) ? 32'd1 : 32'd3);
      checkOutput("fixed_idx", 32'(idx_c), 32'd1);
      applyStimulus(1'b1, 5'h1f, FILT, 1'b1, 1'b1);
    end

    $display("[TB] packet lock and backpressure");
    applyStimulus(1'b1, 5'b00100, ALL3, 1'b1, 1'b0);
    checkOutput("lock_start", 32'(gnt_a), 32'h4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 5'($urandom) & 5'h1b, 15'($urandom), 1'(i % 2), 1'b0);
      checkOutput("lock_hold", 32'(gnt_a), 32'h4);
    end
    applyStimulus(1'b1, 5'h00, ALL3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'h1f, ALL3, 1'b0, 1'b0);
      checkOutput("bp_valid", 32'(gv_a), 32'd0);
    end

    $display("[TB] mid-packet reset and release in idle");
    applyStimulus(1'b1, 5'b00010, ALL3, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'h00, ALL3, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'h1f, ALL3, 1'b1, 1'b0);
    checkOutput("ptr2_idx", 32'(idx_a), 32'd2);
    applyStimulus(1'b0, 5'h1f, ALL3, 1'b1, 1'b1);
    checkOutput("mid_rst_valid", 32'(gv_a), 32'd0);
    applyStimulus(1'b1, 5'h1f, ALL3, 1'b1, 1'b0);
    checkOutput("mid_rst_idx", 32'(idx_a), 32'd0);
    checkOutput("mid_rst_regrant", 32'(gv_a), 32'd1);
    applyStimulus(1'b1, 5'h00, ALL3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'h1f, ALL3, 1'b0, 1'b1);
      checkOutput("idle_rel_valid", 32'(gv_a), 32'd0);
    end
    applyStimulus(1'b1, 5'h1f, ALL3, 1'b1, 1'b0);
    checkOutput("idle_rel_ptr", 32'(idx_a), 32'd1);
    applyStimulus(1'b1, 5'h00, ALL3, 1'b0, 1'b1);

    $display("[TB] five-requester wrap");
    applyStimulus(1'b1, 5'b10000, ALL3, 1'b1, 1'b0);
    checkOutput("wrap_grant4", 32'(idx_b), 32'd4);
    applyStimulus(1'b1, 5'h00, ALL3, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'h1f, ALL3, 1'b1, 1'b0);
    checkOutput("wrap_idx", 32'(idx_b), 32'd0);
    applyStimulus(1'b1, 5'h00, ALL3, 1'b0, 1'b1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 5; k++) begin
        ra[k*3 +: 3] = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'($urandom_range(0, 7));
      end
      applyStimulus(1'($urandom_range(0, 49) != 0), 5'($urandom), ra,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
